// File: rtl/timer_counter.sv
// Down-counting timer: fetches a load value, counts it down once every DIV clocks, flags expiry.
// Latency: read_req one cycle after start; COUNT=N one cycle after CNT_EN; expiry N*DIV cycles later.
// Backpressure: holds read_req in FETCH until the master answers with CNT_EN; stop aborts at any time.
module timer_counter #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       auto_reload,
  input  logic       irq_clear,
  input  logic       CNT_EN,
  input  logic [7:0] LOAD_VALUE,
  output logic       read_req,
  output logic [7:0] COUNT,
  output logic       INTERRUPT,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_FETCH  = 2'b01,
    S_COUNT  = 2'b10,
    S_EXPIRE = 2'b11
  } state_t;

  // Prescaler terminal value; DIV is limited to 1..255 so this fits 8 bits.
  localparam logic [7:0] PRESC_LAST = 8'(DIV - 1);

  state_t     state_q, state_d;
  logic       read_req_q, read_req_d;
  logic [7:0] count_q, count_d;
  logic       irq_q, irq_d;
  logic [7:0] presc_q, presc_d;
  logic       irq_set;

  // Next-state, count and prescaler decisions; stop overrides everything else.
  always_comb begin
    state_d    = state_q;
    read_req_d = read_req_q;
    count_d    = count_q;
    presc_d    = presc_q;
    irq_set    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // CNT_EN arriving here is a late answer to an aborted fetch: ignore it.
        if (start) begin
          state_d    = S_FETCH;
          read_req_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (CNT_EN) begin
          // Drop read_req on this edge so the master never sees a second request.
          read_req_d = 1'b0;
          count_d    = LOAD_VALUE;
          presc_d    = 8'd0;
          if (LOAD_VALUE != 8'd0) begin
            state_d = S_COUNT;
          end else begin
            state_d = S_EXPIRE;
            irq_set = 1'b1;
          end
        end
      end
      S_COUNT: begin
        if (presc_q == PRESC_LAST) begin
          presc_d = 8'd0;
          if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
          end
          if (count_q <= 8'd1) begin
            state_d = S_EXPIRE;
            irq_set = 1'b1;
          end
        end else begin
          presc_d = presc_q + 8'd1;
        end
      end
      S_EXPIRE: begin
        if (auto_reload) begin
          state_d    = S_FETCH;
          read_req_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (stop) begin
      state_d    = S_IDLE;
      read_req_d = 1'b0;
      presc_d    = 8'd0;
      count_d    = count_q;
      irq_set    = 1'b0;
    end

    // A same-cycle expiry wins over irq_clear.
    irq_d = irq_set | (irq_q & ~irq_clear);
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      read_req_q <= 1'b0;
      count_q    <= 8'h00;
      irq_q      <= 1'b0;
      presc_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      read_req_q <= read_req_d;
      count_q    <= count_d;
      irq_q      <= irq_d;
      presc_q    <= presc_d;
    end
  end

  assign read_req  = read_req_q;
  assign COUNT     = count_q;
  assign INTERRUPT = irq_q;
  assign busy      = (state_q != S_IDLE);

endmodule
